// File: rtl/downstream_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// downstream_write_buffer_pkg
// Shared types and default widths for the downstream write buffer.
//   DS_ID_W / DS_AMT_W / DS_DEPTH : default client-index, amount and FIFO depth
//   ds_wr_t                       : one buffered RAM write (index + data)
//   dswb_state_e                  : drain FSM states
// -----------------------------------------------------------------------------
package downstream_write_buffer_pkg;

    localparam int DS_ID_W  = 5;
    localparam int DS_AMT_W = 16;
    localparam int DS_DEPTH = 4;

    typedef struct packed {
        logic [DS_ID_W-1:0]  wrindex;
        logic [DS_AMT_W-1:0] wdata;
    } ds_wr_t;

    typedef enum logic [0:0] {
        DSWB_IDLE  = 1'b0,
        DSWB_ISSUE = 1'b1
    } dswb_state_e;

endpackage : downstream_write_buffer_pkg

// File: rtl/downstream_write_buffer_fifo.sv
// -----------------------------------------------------------------------------
// ds_wr_fifo
// Synchronous FIFO of RAM write entries with an exact occupancy count.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/din_i  : write an entry (ignored when full)
//   pop_i         : discard the head (ignored when empty)
//   dout_o        : head entry, combinational read
//   dout_next_o   : entry behind the head, lets the consumer chain writes
//   full_o/empty_o/count_o : status decoded from the registered count
// -----------------------------------------------------------------------------
module ds_wr_fifo
    import downstream_write_buffer_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = ds_wr_t
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  entry_t                       din_i,
    output entry_t                       dout_o,
    output entry_t                       dout_next_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o      = (count_q == CNT_FULL);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign do_push_s   = push_i && !full_o;
    assign do_pop_s    = pop_i && !empty_o;
    assign dout_o      = mem_q[rd_ptr_q];
    // Pointers are power-of-two wide, so the +1 wraps modulo DEPTH for free.
    assign dout_next_o = mem_q[rd_ptr_q + PTR_ONE];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : ds_wr_fifo

// File: rtl/downstream_write_buffer.sv
// -----------------------------------------------------------------------------
// downstream_write_buffer
// Buffers client balance updates, drops back-to-back duplicates and drains the
// rest one at a time as write requests to the downstream RAM.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid/in_client_id/in_amount  : update offered by the producer
//   in_ready                         : buffer can accept (FIFO not full)
//   ram_we/ram_wrindex/ram_wdata     : write request, held until ram_ack
//   ram_ack                          : RAM accepted the current write
//   count                            : FIFO occupancy
//   dup_drop                         : one-cycle pulse, update dropped as dup
// -----------------------------------------------------------------------------
module downstream_write_buffer
    import downstream_write_buffer_pkg::*;
#(
    parameter int DEPTH = DS_DEPTH,
    parameter int ID_W  = DS_ID_W,
    parameter int AMT_W = DS_AMT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [ID_W-1:0]             in_client_id,
    input  logic [AMT_W-1:0]            in_amount,
    output logic                        in_ready,
    output logic                        ram_we,
    output logic [ID_W-1:0]             ram_wrindex,
    output logic [AMT_W-1:0]            ram_wdata,
    input  logic                        ram_ack,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        dup_drop
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Same layout as ds_wr_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ID_W-1:0]  wrindex;
        logic [AMT_W-1:0] wdata;
    } entry_t;

    entry_t        din_s;
    entry_t        head_s;
    entry_t        head_next_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic          accept_s;
    logic          dup_s;
    logic          push_s;
    logic          pop_s;

    dswb_state_e      state_q;
    logic             ram_we_q;
    logic [ID_W-1:0]  ram_wrindex_q;
    logic [AMT_W-1:0] ram_wdata_q;
    logic             last_vld_q;
    logic [ID_W-1:0]  last_id_q;
    logic [AMT_W-1:0] last_amt_q;
    logic             dup_drop_q;

    // full_s comes straight from the registered count, so a pop in this cycle
    // cannot raise in_ready and ram_ack has no combinational path to it.
    assign in_ready = !full_s;
    assign accept_s = in_valid && in_ready;
    assign dup_s    = last_vld_q && (in_client_id == last_id_q) && (in_amount == last_amt_q);
    assign push_s   = accept_s && !dup_s;
    // ISSUE is exactly the ram_we=1 state, so acks outside it are ignored.
    assign pop_s    = (state_q == DSWB_ISSUE) && ram_ack;

    assign din_s.wrindex = in_client_id;
    assign din_s.wdata   = in_amount;

    ds_wr_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .din_i       (din_s),
        .dout_o      (head_s),
        .dout_next_o (head_next_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .count_o     (count_s)
    );

    // Duplicate filter: tracks the last accepted update, not RAM completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld_q <= 1'b0;
            last_id_q  <= '0;
            last_amt_q <= '0;
            dup_drop_q <= 1'b0;
        end else begin
            dup_drop_q <= accept_s && dup_s;
            if (accept_s) begin
                last_vld_q <= 1'b1;
                last_id_q  <= in_client_id;
                last_amt_q <= in_amount;
            end
        end
    end

    // Drain FSM with registered RAM request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DSWB_IDLE;
            ram_we_q      <= 1'b0;
            ram_wrindex_q <= '0;
            ram_wdata_q   <= '0;
        end else begin
            case (state_q)
                DSWB_IDLE: begin
                    if (!empty_s) begin
                        ram_wrindex_q <= head_s.wrindex;
                        ram_wdata_q   <= head_s.wdata;
                        ram_we_q      <= 1'b1;
                        state_q       <= DSWB_ISSUE;
                    end
                end
                DSWB_ISSUE: begin
                    if (ram_ack) begin
                        // The head is popped at this edge; the entry behind it
                        // becomes the next write without a bubble cycle.
                        if (count_s > CNT_ONE) begin
                            ram_wrindex_q <= head_next_s.wrindex;
                            ram_wdata_q   <= head_next_s.wdata;
                            ram_we_q      <= 1'b1;
                            state_q       <= DSWB_ISSUE;
                        end else begin
                            ram_we_q <= 1'b0;
                            state_q  <= DSWB_IDLE;
                        end
                    end
                end
                default: begin
                    ram_we_q <= 1'b0;
                    state_q  <= DSWB_IDLE;
                end
            endcase
        end
    end

    assign ram_we      = ram_we_q;
    assign ram_wrindex = ram_wrindex_q;
    assign ram_wdata   = ram_wdata_q;
    assign count       = count_s;
    assign dup_drop    = dup_drop_q;

endmodule : downstream_write_buffer
